// File: rtl/jump_ras_predict_pkg.sv
// Shared opcode/funct encodings and the jump decode helper for the D-stage jump unit.
// Imported by jump_ras_predict; the perf counters there are enabled by JUMP_PERF_CNT_EN.
package jump_ras_predict_pkg;

   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_J       = 6'b000010;
   localparam logic [5:0] OP_JAL     = 6'b000011;
   localparam logic [5:0] FUNCT_JR   = 6'b001000;
   localparam logic [5:0] FUNCT_JALR = 6'b001001;
   localparam logic [4:0] REG_RA     = 5'd31;

   typedef struct packed {
      logic j_imm;  // j, jal
      logic jreg;   // jr, jalr
      logic link;   // jal, jalr
      logic ret;    // jr $31 only
   } jump_dec_t;

   function automatic jump_dec_t decode_jump(input logic [5:0] op,
                                             input logic [4:0] rs,
                                             input logic [5:0] funct);
      jump_dec_t d;
      d.j_imm = (op[5:1] == OP_J[5:1]);
      d.jreg  = (op == OP_SPECIAL) && (funct[5:1] == FUNCT_JR[5:1]);
      d.link  = (op == OP_JAL) || (d.jreg && (funct == FUNCT_JALR));
      d.ret   = (op == OP_SPECIAL) && (funct == FUNCT_JR) && (rs == REG_RA);
      return d;
   endfunction

endpackage

// File: rtl/jump_ras_predict_ras_stack.sv
// Circular return-address stack: top pointer plus a count that saturates at RAS_DEPTH.
// A push when full silently overwrites the oldest entry; a pop when empty does nothing.
module ras_stack #(
   parameter int RAS_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  logic        pop,
   input  logic [31:0] push_data,
   output logic [31:0] top,
   output logic        empty
);

   localparam int RAS_PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W     = RAS_PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

   logic [31:0]          mem [RAS_DEPTH];
   logic [RAS_PTR_W-1:0] ptr;
   logic [CNT_W-1:0]     count;
   logic [RAS_PTR_W-1:0] ptr_up;

   assign ptr_up = ptr + RAS_PTR_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr   <= '0;
         count <= '0;
         for (int i = 0; i < RAS_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push) begin
         ptr         <= ptr_up;
         mem[ptr_up] <= push_data;
         if (count != FULL) begin
            count <= count + CNT_W'(1);
         end
      end else if (pop && (count != '0)) begin
         ptr   <= ptr - RAS_PTR_W'(1);
         count <= count - CNT_W'(1);
      end
   end

   assign top   = mem[ptr];
   assign empty = (count == '0);

endmodule

// File: rtl/jump_ras_predict.sv
// D-stage jump unit: decode, RAS push/pop, jr $31 prediction under hazard and E-stage verify.
// Define JUMP_PERF_CNT_EN to build the prediction/mispredict counters; otherwise they read 0.
module jump_ras_predict
   import jump_ras_predict_pkg::*;
#(
   parameter int RAS_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instrD,
   input  logic [31:0] pc_plus4D,
   input  logic [31:0] rd1D,
   input  logic        regwriteE,
   input  logic        regwriteM,
   input  logic [4:0]  writeregE,
   input  logic [4:0]  writeregM,
   input  logic        stallD,
   input  logic        flushD,
   input  logic        stallE,
   input  logic        flushE,
   input  logic [31:0] rs_valueE,
   output logic        jumpD,
   output logic        jump_conflictD,
   output logic [31:0] pc_jumpD,
   output logic        ras_hitD,
   output logic        mispredictE,
   output logic [31:0] pc_correctE,
   output logic        ras_emptyo,
   output logic [31:0] perf_pred,
   output logic [31:0] perf_miss
);

   jump_dec_t   dec;
   logic [4:0]  rs;
   logic        haz;
   logic        adv;
   logic [31:0] ras_top;
   logic        ras_empty;
   logic        pred_v;
   logic [31:0] pred_t;

   assign rs  = instrD[25:21];
   assign dec = decode_jump(instrD[31:26], rs, instrD[5:0]);

   assign haz = dec.jreg & ((regwriteE & (rs == writeregE)) |
                            (regwriteM & (rs == writeregM)));

   assign jumpD          = dec.j_imm | dec.jreg;
   assign ras_hitD       = dec.ret & haz & ~ras_empty;
   assign jump_conflictD = haz & ~ras_hitD;
   assign adv            = ~stallD & ~flushD & ~jump_conflictD;
   assign ras_emptyo     = ras_empty;

   always_comb begin
      pc_jumpD = rd1D;
      if (dec.j_imm) begin
         pc_jumpD = {pc_plus4D[31:28], instrD[25:0], 2'b00};
      end else if (ras_hitD) begin
         pc_jumpD = ras_top;
      end
   end

   // Link address skips the delay slot; a ret pops even when unpredicted to stay in sync.
   ras_stack #(.RAS_DEPTH(RAS_DEPTH)) u_ras (
      .clk       (clk),
      .rst       (rst),
      .push      (dec.link & adv),
      .pop       (dec.ret & adv),
      .push_data (pc_plus4D + 32'd4),
      .top       (ras_top),
      .empty     (ras_empty)
   );

   always_ff @(posedge clk) begin
      if (rst || flushE) begin
         pred_v <= 1'b0;
         pred_t <= '0;
      end else if (!stallE) begin
         pred_v <= ras_hitD & adv;
         pred_t <= ras_top;
      end
   end

   assign mispredictE = pred_v & (pred_t != rs_valueE);
   assign pc_correctE = rs_valueE;

`ifdef JUMP_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_pred <= '0;
         perf_miss <= '0;
      end else begin
         if (ras_hitD && adv) begin
            perf_pred <= perf_pred + 32'd1;
         end
         if (mispredictE && !stallE) begin
            perf_miss <= perf_miss + 32'd1;
         end
      end
   end
`else
   assign perf_pred = '0;
   assign perf_miss = '0;
`endif

endmodule

// File: tb/tb_jump_ras_predict.sv
// Directed bench for jump_ras_predict: a queue-based RAS model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_jump_ras_predict;

   localparam int DEPTH = 8;
   localparam logic [31:0] JAL_I = 32'h0C100200;  // target 0x?0400800
   localparam logic [31:0] J_I   = 32'h08000010;  // target {pc[31:28],0x40}
   localparam logic [31:0] JR31  = 32'h03E00008;
   localparam logic [31:0] JR5   = 32'h00A00008;
   localparam logic [31:0] JALR2 = 32'h0040F809;
   localparam logic [31:0] JALR31 = 32'h03E0F809;
   localparam logic [31:0] NOP   = 32'h00000000;

   logic        clk, rst;
   logic [31:0] instrD, pc_plus4D, rd1D, rs_valueE;
   logic        regwriteE, regwriteM, stallD, flushD, stallE, flushE;
   logic [4:0]  writeregE, writeregM;
   logic        jumpD, jump_conflictD, ras_hitD, mispredictE, ras_emptyo;
   logic [31:0] pc_jumpD, pc_correctE, perf_pred, perf_miss;

   jump_ras_predict #(.RAS_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .instrD(instrD), .pc_plus4D(pc_plus4D), .rd1D(rd1D),
      .regwriteE(regwriteE), .regwriteM(regwriteM), .writeregE(writeregE),
      .writeregM(writeregM), .stallD(stallD), .flushD(flushD), .stallE(stallE),
      .flushE(flushE), .rs_valueE(rs_valueE), .jumpD(jumpD),
      .jump_conflictD(jump_conflictD), .pc_jumpD(pc_jumpD), .ras_hitD(ras_hitD),
      .mispredictE(mispredictE), .pc_correctE(pc_correctE), .ras_emptyo(ras_emptyo),
      .perf_pred(perf_pred), .perf_miss(perf_miss)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // scoreboard state
   int          n_vec  = 0;
   int          n_fail = 0;
   logic [31:0] exp_q[$];

   // model state
   logic [31:0] ras_q[$];
   bit          m_pv = 1'b0;
   logic [31:0] m_pt = '0;
   logic [31:0] m_pred = '0;
   logic [31:0] m_miss = '0;
   bit          started = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_eval(output bit ij, output bit jr, output bit lk, output bit rt,
                             output bit hit, output bit cf, output bit ad);
      logic [5:0] op, fn;
      logic [4:0] rs;
      bit hz;
      op  = instrD[31:26];
      fn  = instrD[5:0];
      rs  = instrD[25:21];
      ij  = (op == 6'd2) || (op == 6'd3);
      jr  = (op == 6'd0) && (fn == 6'd8 || fn == 6'd9);
      lk  = (op == 6'd3) || (op == 6'd0 && fn == 6'd9);
      rt  = (op == 6'd0) && (fn == 6'd8) && (rs == 5'd31);
      hz  = jr && ((regwriteE && rs == writeregE) || (regwriteM && rs == writeregM));
      hit = rt && hz && (ras_q.size() != 0);
      cf  = hz && !hit;
      ad  = !stallD && !flushD && !cf;
   endtask

   // model update on the active edge
   always @(posedge clk) begin
      bit ij, jr, lk, rt, hit, cf, ad;
      logic [31:0] top;
      if (rst) begin
         ras_q.delete();
         m_pv = 1'b0; m_pt = '0; m_pred = '0; m_miss = '0;
         started = 1'b1;
      end else begin
         model_eval(ij, jr, lk, rt, hit, cf, ad);
         top = (ras_q.size() != 0) ? ras_q[$] : 32'h0;
`ifdef JUMP_PERF_CNT_EN
         if (m_pv && (m_pt != rs_valueE) && !stallE) m_miss = m_miss + 32'd1;
         if (hit && ad) m_pred = m_pred + 32'd1;
`endif
         if (flushE) m_pv = 1'b0;
         else if (!stallE) begin
            m_pv = hit && ad;
            m_pt = top;
         end
         if (lk && ad) begin
            ras_q.push_back(pc_plus4D + 32'd4);
            if (ras_q.size() > DEPTH) void'(ras_q.pop_front());
         end else if (rt && ad && ras_q.size() != 0) begin
            void'(ras_q.pop_back());
         end
      end
   end

   // compare process on the opposite edge
   always @(negedge clk) begin
      bit ij, jr, lk, rt, hit, cf, ad;
      logic [31:0] exp_pc;
      bit exp_mis;
      if (started) begin
         model_eval(ij, jr, lk, rt, hit, cf, ad);
         chk("jumpD", {31'd0, jumpD}, {31'd0, ij || jr});
         chk("ras_hitD", {31'd0, ras_hitD}, {31'd0, hit});
         chk("jump_conflictD", {31'd0, jump_conflictD}, {31'd0, cf});
         if (ij || jr) begin
            if (ij) exp_pc = {pc_plus4D[31:28], instrD[25:0], 2'b00};
            else if (hit) exp_pc = ras_q[$];
            else exp_pc = rd1D;
            chk("pc_jumpD", pc_jumpD, exp_pc);
         end
         exp_mis = m_pv && (m_pt != rs_valueE);
         chk("mispredictE", {31'd0, mispredictE}, {31'd0, exp_mis});
         if (exp_mis) chk("pc_correctE", pc_correctE, rs_valueE);
         chk("ras_emptyo", {31'd0, ras_emptyo}, {31'd0, ras_q.size() == 0});
         chk("perf_pred", perf_pred, m_pred);
         chk("perf_miss", perf_miss, m_miss);
      end
   end

   // driver tasks
   task automatic idle();
      instrD = NOP; pc_plus4D = '0; rd1D = '0; rs_valueE = '0;
      regwriteE = 1'b0; regwriteM = 1'b0; writeregE = '0; writeregM = '0;
      stallD = 1'b0; flushD = 1'b0; stallE = 1'b0; flushE = 1'b0;
   endtask

   task automatic put(input logic [31:0] instr, input logic [31:0] pc4, input logic [31:0] rd1);
      instrD = instr; pc_plus4D = pc4; rd1D = rd1;
   endtask

   task automatic hazard_e31(input logic on);
      regwriteE = on; writeregE = on ? 5'd31 : 5'd0;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic next();
      @(posedge clk);
      #1;
      idle();
   endtask

   initial begin
`ifdef JUMP_PERF_CNT_EN
      localparam bit PERF = 1'b1;
`else
      localparam bit PERF = 1'b0;
`endif
      rst = 1'b1;
      idle();
      @(posedge clk); #1;
      settle();
      chk("reset empty", {31'd0, ras_emptyo}, 32'd1);
      chk("reset mispredict", {31'd0, mispredictE}, 32'd0);
      chk("reset hit", {31'd0, ras_hitD}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // 1: jal then unhazarded jr $31 pops, target from rd1D
      put(JAL_I, 32'h00400104, 32'h0); settle();
      chk("t1 jal target", pc_jumpD, 32'h00400800);
      next();
      put(JR31, 32'h00400108, 32'h00400108); settle();
      chk("t1 jr target", pc_jumpD, 32'h00400108);
      chk("t1 jr hit", {31'd0, ras_hitD}, 32'd0);
      next(); settle();
      chk("t1 empty after", {31'd0, ras_emptyo}, 32'd1);
      next();

      // 2: predicted jr, correct
      put(JAL_I, 32'h00400104, 32'h0); next();
      put(JR31, 32'h00400108, 32'hDEAD0000); hazard_e31(1'b1); settle();
      chk("t2 conflict", {31'd0, jump_conflictD}, 32'd0);
      chk("t2 hit", {31'd0, ras_hitD}, 32'd1);
      chk("t2 target", pc_jumpD, 32'h00400108);
      next();
      rs_valueE = 32'h00400108; settle();
      chk("t2 mispredict", {31'd0, mispredictE}, 32'd0);
      next();

      // 3: predicted jr, wrong
      put(JAL_I, 32'h00400104, 32'h0); next();
      put(JR31, 32'h00400108, 32'h0); hazard_e31(1'b1); next();
      rs_valueE = 32'h00401000; settle();
      chk("t3 mispredict", {31'd0, mispredictE}, 32'd1);
      chk("t3 pc_correct", pc_correctE, 32'h00401000);
      next(); settle();
      chk("t3 perf_miss", perf_miss, PERF ? 32'd1 : 32'd0);
      chk("t3 perf_pred", perf_pred, PERF ? 32'd2 : 32'd0);
      next();

      // 4: jr $5 with M hazard stalls and leaves the stack alone
      put(JAL_I, 32'h00400204, 32'h0); next();
      put(JR5, 32'h00400300, 32'h0); regwriteM = 1'b1; writeregM = 5'd5; settle();
      chk("t4 conflict", {31'd0, jump_conflictD}, 32'd1);
      chk("t4 hit", {31'd0, ras_hitD}, 32'd0);
      next();
      put(JR31, 32'h00400300, 32'h0); hazard_e31(1'b1); settle();
      chk("t4 top unchanged", pc_jumpD, 32'h00400208);
      next();
      rs_valueE = 32'h00400208;
      put(J_I, 32'h90000010, 32'h0); settle();
      chk("j target", pc_jumpD, 32'h90000040);
      next();
      // jalr under hazard is not a ret: it stalls and does not push
      put(JALR31, 32'h00400400, 32'h0); hazard_e31(1'b1); settle();
      chk("jalr31 conflict", {31'd0, jump_conflictD}, 32'd1);
      next();
      put(JALR2, 32'h00400300, 32'h00001234); settle();
      chk("jalr target", pc_jumpD, 32'h00001234);
      next();
      put(JR31, 32'h0, 32'h0); hazard_e31(1'b1); settle();
      chk("jalr link", pc_jumpD, 32'h00400304);
      next();
      // stalled / flushed jal must not push
      put(JAL_I, 32'h00400500, 32'h0); stallD = 1'b1; next();
      put(JAL_I, 32'h00400600, 32'h0); flushD = 1'b1; next();
      settle();
      chk("no push on stall/flush", {31'd0, ras_emptyo}, 32'd1);
      next();
      // flushE kills a pending prediction
      put(JAL_I, 32'h00400700, 32'h0); next();
      put(JR31, 32'h0, 32'h0); hazard_e31(1'b1); next();
      rs_valueE = 32'h1; flushE = 1'b1; next();
      rs_valueE = 32'h1; settle();
      chk("flushE clears", {31'd0, mispredictE}, 32'd0);
      next();

      // 5: overflow then LIFO drain
      for (int i = 0; i < 9; i++) begin
         put(JAL_I, 32'h00500000 + 32'(16 * i), 32'h0); next();
      end
      for (int i = 8; i >= 1; i--) exp_q.push_back(32'h00500004 + 32'(16 * i));
      for (int k = 0; k < 9; k++) begin
         put(JR31, 32'h0, 32'h0); hazard_e31(1'b1); settle();
         if (k < 8) begin
            chk("t5 hit", {31'd0, ras_hitD}, 32'd1);
            chk("t5 lifo", pc_jumpD, exp_q.pop_front());
         end else begin
            chk("t5 9th hit", {31'd0, ras_hitD}, 32'd0);
            chk("t5 9th conflict", {31'd0, jump_conflictD}, 32'd1);
         end
         next();
      end

      // 6: reset while a wrong prediction sits stalled in E
      put(JAL_I, 32'h00600000, 32'h0); next();
      put(JR31, 32'h0, 32'h0); hazard_e31(1'b1); next();
      stallE = 1'b1; rs_valueE = 32'h0; settle();
      chk("t6 mispredict", {31'd0, mispredictE}, 32'd1);
      next();
      stallE = 1'b1; rs_valueE = 32'h0; settle();
      chk("t6 sustained", {31'd0, mispredictE}, 32'd1);
      next();
      stallE = 1'b1; rst = 1'b1; next();
      stallE = 1'b1; settle();
      chk("t6 mispredict after rst", {31'd0, mispredictE}, 32'd0);
      chk("t6 empty after rst", {31'd0, ras_emptyo}, 32'd1);
      chk("t6 perf_pred after rst", perf_pred, 32'd0);
      chk("t6 perf_miss after rst", perf_miss, 32'd0);
      next();
      rst = 1'b0;
      repeat (3) next();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
